// File: rtl/cnn_layer_sequencer_if.sv
// Bundle of the sequencer's start handshake, memory-port controls and datapath strobes.
// The master modport is the sequencer; the slave modport is the datapath/memory side.
interface cnn_layer_sequencer_if #(
    parameter int IMG_LOG2 = 6
);
    localparam int AW = 2 * IMG_LOG2;

    logic          ready;
    logic          busy;
    logic          done;
    logic [AW-1:0] iaddr;
    logic          crd;
    logic [AW-1:0] caddr_rd;
    logic          cwr;
    logic [AW-1:0] caddr_wr;
    logic [2:0]    csel;
    logic [3:0]    tap_idx;
    logic          tap_pad;
    logic          mac_clr;
    logic          mac_en;
    logic          pool_clr;
    logic          pool_en;
    logic          flat_ld;
    logic [1:0]    wr_src;

    modport master (
        input  ready,
        output busy, done, iaddr, crd, caddr_rd, cwr, caddr_wr, csel,
               tap_idx, tap_pad, mac_clr, mac_en, pool_clr, pool_en, flat_ld, wr_src
    );

    modport slave (
        output ready,
        input  busy, done, iaddr, crd, caddr_rd, cwr, caddr_wr, csel,
               tap_idx, tap_pad, mac_clr, mac_en, pool_clr, pool_en, flat_ld, wr_src
    );
endinterface

// File: rtl/cnn_layer_sequencer.sv
// Control FSM sequencing conv (3x3, zero pad, 2 kernels), 2x2 max-pool and flatten.
// Outputs decode from registered state/counters; only csel history and done are held separately.
module cnn_layer_sequencer #(
    parameter int IMG_LOG2 = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    cnn_layer_sequencer_if.master bus
);
    localparam int AW = 2 * IMG_LOG2;
    localparam int P  = IMG_LOG2 - 1;
    localparam int PW = 2 * P;
    localparam logic [IMG_LOG2:0] ONE_E = {{IMG_LOG2{1'b0}}, 1'b1};

    typedef enum logic [1:0] {S_IDLE, S_L0, S_L1, S_L2} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] pix_q, pix_d;
    logic [3:0]    step_q, step_d;
    logic          kern_q, kern_d;
    logic [2:0]    csel_q, csel_d;
    logic          done_q, done_d;

    logic [IMG_LOG2-1:0] row, col;
    logic [1:0]          tr, tc;
    logic [IMG_LOG2:0]   rr, cc;
    logic                pad;
    logic                last_pw;

    assign row     = pix_q[AW-1:IMG_LOG2];
    assign col     = pix_q[IMG_LOG2-1:0];
    assign last_pw = &pix_q[PW-1:0];

    // Tap offsets: an out-of-range neighbour shows up as the extra top bit (-1 wraps, N overflows).
    always_comb begin
        tr = 2'd0;
        tc = 2'd0;
        case (step_q)
            4'd1: tc = 2'd1;
            4'd2: tc = 2'd2;
            4'd3: tr = 2'd1;
            4'd4: begin tr = 2'd1; tc = 2'd1; end
            4'd5: begin tr = 2'd1; tc = 2'd2; end
            4'd6: tr = 2'd2;
            4'd7: begin tr = 2'd2; tc = 2'd1; end
            4'd8: begin tr = 2'd2; tc = 2'd2; end
            default: ;
        endcase
        rr  = {1'b0, row} + {{(IMG_LOG2-1){1'b0}}, tr} - ONE_E;
        cc  = {1'b0, col} + {{(IMG_LOG2-1){1'b0}}, tc} - ONE_E;
        pad = rr[IMG_LOG2] | cc[IMG_LOG2];
    end

    always_comb begin
        state_d = state_q;
        pix_d   = pix_q;
        step_d  = step_q;
        kern_d  = kern_q;
        csel_d  = csel_q;
        done_d  = 1'b0;

        bus.busy     = 1'b0;
        bus.done     = done_q;
        bus.iaddr    = '0;
        bus.crd      = 1'b0;
        bus.caddr_rd = '0;
        bus.cwr      = 1'b0;
        bus.caddr_wr = '0;
        bus.csel     = csel_q;
        bus.tap_idx  = '0;
        bus.tap_pad  = 1'b0;
        bus.mac_clr  = 1'b0;
        bus.mac_en   = 1'b0;
        bus.pool_clr = 1'b0;
        bus.pool_en  = 1'b0;
        bus.flat_ld  = 1'b0;
        bus.wr_src   = 2'b00;

        case (state_q)
            S_IDLE: begin
                bus.csel = '0;
                if (bus.ready) begin
                    state_d = S_L0;
                    pix_d   = '0;
                    step_d  = '0;
                    kern_d  = 1'b0;
                    csel_d  = '0;
                end
            end
            S_L0: begin
                bus.busy = 1'b1;
                if (step_q < 4'd9) begin
                    bus.mac_en  = 1'b1;
                    bus.mac_clr = (step_q == 4'd0);
                    bus.tap_idx = step_q;
                    bus.tap_pad = pad;
                    bus.iaddr   = pad ? '0 : {rr[IMG_LOG2-1:0], cc[IMG_LOG2-1:0]};
                    step_d      = step_q + 4'd1;
                end else begin
                    bus.cwr      = 1'b1;
                    bus.caddr_wr = pix_q;
                    if (step_q == 4'd9) begin
                        bus.csel = 3'b001;
                        bus.wr_src = 2'b00;
                        step_d   = step_q + 4'd1;
                    end else begin
                        bus.csel   = 3'b010;
                        bus.wr_src = 2'b01;
                        step_d     = '0;
                        pix_d      = pix_q + 1'b1;
                        if (&pix_q) state_d = S_L1;
                    end
                    csel_d = bus.csel;
                end
            end
            S_L1: begin
                bus.busy = 1'b1;
                if (step_q < 4'd4) begin
                    bus.crd      = 1'b1;
                    bus.csel     = kern_q ? 3'b010 : 3'b001;
                    bus.caddr_rd = {pix_q[PW-1:P], step_q[1], pix_q[P-1:0], step_q[0]};
                    bus.pool_clr = (step_q == 4'd0);
                    bus.pool_en  = (step_q != 4'd0);
                    step_d       = step_q + 4'd1;
                end else begin
                    bus.cwr      = 1'b1;
                    bus.csel     = kern_q ? 3'b100 : 3'b011;
                    bus.caddr_wr = {2'b00, pix_q[PW-1:0]};
                    bus.wr_src   = 2'b10;
                    step_d       = '0;
                    if (last_pw) begin
                        pix_d = '0;
                        if (kern_q) state_d = S_L2;
                        else        kern_d  = 1'b1;
                    end else begin
                        pix_d = pix_q + 1'b1;
                    end
                end
                csel_d = bus.csel;
            end
            S_L2: begin
                bus.busy = 1'b1;
                step_d   = step_q + 4'd1;
                case (step_q[1:0])
                    2'd0: begin
                        bus.crd      = 1'b1;
                        bus.csel     = 3'b011;
                        bus.caddr_rd = {2'b00, pix_q[PW-1:0]};
                        bus.flat_ld  = 1'b1;
                    end
                    2'd1: begin
                        bus.cwr      = 1'b1;
                        bus.csel     = 3'b101;
                        bus.caddr_wr = {1'b0, pix_q[PW-1:0], 1'b0};
                        bus.wr_src   = 2'b11;
                    end
                    2'd2: begin
                        bus.crd      = 1'b1;
                        bus.csel     = 3'b100;
                        bus.caddr_rd = {2'b00, pix_q[PW-1:0]};
                        bus.flat_ld  = 1'b1;
                    end
                    default: begin
                        bus.cwr      = 1'b1;
                        bus.csel     = 3'b101;
                        bus.caddr_wr = {1'b0, pix_q[PW-1:0], 1'b1};
                        bus.wr_src   = 2'b11;
                        step_d       = '0;
                        if (last_pw) begin
                            state_d = S_IDLE;
                            pix_d   = '0;
                            done_d  = 1'b1;
                        end else begin
                            pix_d = pix_q + 1'b1;
                        end
                    end
                endcase
                csel_d = (state_d == S_IDLE) ? 3'b000 : bus.csel;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            pix_q   <= '0;
            step_q  <= '0;
            kern_q  <= 1'b0;
            csel_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pix_q   <= pix_d;
            step_q  <= step_d;
            kern_q  <= kern_d;
            csel_q  <= csel_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Scoreboard bench: a loop-nest model of the three layers queues every expected busy cycle.
// A 64x64 instance runs the full sequence; an 8x8 instance covers mid-run reset and restart.
module tb_cnn_layer_sequencer;
    typedef struct packed {
        logic [11:0] iaddr;
        logic        crd;
        logic [11:0] caddr_rd;
        logic        cwr;
        logic [11:0] caddr_wr;
        logic [2:0]  csel;
        logic [3:0]  tap_idx;
        logic        tap_pad;
        logic        mac_clr;
        logic        mac_en;
        logic        pool_clr;
        logic        pool_en;
        logic        flat_ld;
        logic [1:0]  wr_src;
    } exp_t;

    logic clk = 1'b0;
    logic rst_a, rst_b;
    int   total = 0;
    int   bad   = 0;
    exp_t q[$];
    exp_t obs_a, obs_b;

    always #5 clk = ~clk;

    cnn_layer_sequencer_if #(.IMG_LOG2(6)) ifa ();
    cnn_layer_sequencer_if #(.IMG_LOG2(3)) ifb ();

    cnn_layer_sequencer #(.IMG_LOG2(6)) dut_a (.clk(clk), .reset(rst_a), .bus(ifa));
    cnn_layer_sequencer #(.IMG_LOG2(3)) dut_b (.clk(clk), .reset(rst_b), .bus(ifb));

    always_comb begin
        obs_a.iaddr    = ifa.iaddr;
        obs_a.crd      = ifa.crd;
        obs_a.caddr_rd = ifa.caddr_rd;
        obs_a.cwr      = ifa.cwr;
        obs_a.caddr_wr = ifa.caddr_wr;
        obs_a.csel     = ifa.csel;
        obs_a.tap_idx  = ifa.tap_idx;
        obs_a.tap_pad  = ifa.tap_pad;
        obs_a.mac_clr  = ifa.mac_clr;
        obs_a.mac_en   = ifa.mac_en;
        obs_a.pool_clr = ifa.pool_clr;
        obs_a.pool_en  = ifa.pool_en;
        obs_a.flat_ld  = ifa.flat_ld;
        obs_a.wr_src   = ifa.wr_src;
    end

    always_comb begin
        obs_b.iaddr    = 12'(ifb.iaddr);
        obs_b.crd      = ifb.crd;
        obs_b.caddr_rd = 12'(ifb.caddr_rd);
        obs_b.cwr      = ifb.cwr;
        obs_b.caddr_wr = 12'(ifb.caddr_wr);
        obs_b.csel     = ifb.csel;
        obs_b.tap_idx  = ifb.tap_idx;
        obs_b.tap_pad  = ifb.tap_pad;
        obs_b.mac_clr  = ifb.mac_clr;
        obs_b.mac_en   = ifb.mac_en;
        obs_b.pool_clr = ifb.pool_clr;
        obs_b.pool_en  = ifb.pool_en;
        obs_b.flat_ld  = ifb.flat_ld;
        obs_b.wr_src   = ifb.wr_src;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_run(input int lg);
        int n, p, rr, cc;
        logic [2:0] last;
        exp_t e;
        n = 1 << lg;
        p = n / 2;
        last = 3'b000;
        for (int r = 0; r < n; r++) begin
            for (int c = 0; c < n; c++) begin
                for (int t = 0; t < 9; t++) begin
                    e = '0;
                    e.mac_en  = 1'b1;
                    e.mac_clr = (t == 0);
                    e.tap_idx = 4'(t);
                    e.csel    = last;
                    rr = r + t / 3 - 1;
                    cc = c + t % 3 - 1;
                    if (rr < 0 || rr >= n || cc < 0 || cc >= n) e.tap_pad = 1'b1;
                    else e.iaddr = 12'(rr * n + cc);
                    q.push_back(e);
                end
                e = '0;
                e.cwr = 1'b1;
                e.caddr_wr = 12'(r * n + c);
                e.csel = 3'b001;
                e.wr_src = 2'b00;
                q.push_back(e);
                e.csel = 3'b010;
                e.wr_src = 2'b01;
                q.push_back(e);
                last = 3'b010;
            end
        end
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < p; r++) begin
                for (int c = 0; c < p; c++) begin
                    for (int j = 0; j < 4; j++) begin
                        e = '0;
                        e.crd = 1'b1;
                        e.csel = (k == 1) ? 3'b010 : 3'b001;
                        e.caddr_rd = 12'((2 * r + j / 2) * n + 2 * c + j % 2);
                        e.pool_clr = (j == 0);
                        e.pool_en  = (j != 0);
                        q.push_back(e);
                    end
                    e = '0;
                    e.cwr = 1'b1;
                    e.csel = (k == 1) ? 3'b100 : 3'b011;
                    e.caddr_wr = 12'(r * p + c);
                    e.wr_src = 2'b10;
                    q.push_back(e);
                end
            end
        end
        for (int i = 0; i < p * p; i++) begin
            e = '0; e.crd = 1'b1; e.csel = 3'b011; e.caddr_rd = 12'(i); e.flat_ld = 1'b1;
            q.push_back(e);
            e = '0; e.cwr = 1'b1; e.csel = 3'b101; e.caddr_wr = 12'(2 * i); e.wr_src = 2'b11;
            q.push_back(e);
            e = '0; e.crd = 1'b1; e.csel = 3'b100; e.caddr_rd = 12'(i); e.flat_ld = 1'b1;
            q.push_back(e);
            e = '0; e.cwr = 1'b1; e.csel = 3'b101; e.caddr_wr = 12'(2 * i + 1); e.wr_src = 2'b11;
            q.push_back(e);
        end
    endtask

    task automatic test_reset();
        ifa.ready = 1'b0;
        ifb.ready = 1'b0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (3) tick();
        total++;
        if (obs_a !== '0 || ifa.busy !== 1'b0 || ifa.done !== 1'b0) begin
            bad++;
            $display("FAIL reset_a got=%h busy=%b done=%b want all zero", obs_a, ifa.busy, ifa.done);
        end
        total++;
        if (obs_b !== '0 || ifb.busy !== 1'b0 || ifb.done !== 1'b0) begin
            bad++;
            $display("FAIL reset_b got=%h busy=%b done=%b want all zero", obs_b, ifb.busy, ifb.done);
        end
        rst_a = 1'b0;
        rst_b = 1'b0;
        repeat (2) tick();
        total++;
        if (ifa.busy !== 1'b0 || ifb.busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_no_ready got busy_a=%b busy_b=%b want 0", ifa.busy, ifb.busy);
        end
    endtask

    task automatic test_full_run();
        int cyc, busy_cnt, both;
        exp_t e;
        q.delete();
        push_run(6);
        ifa.ready = 1'b1;
        tick();
        ifa.ready = 1'b0;
        total++;
        if (ifa.busy !== 1'b1 || ifa.iaddr !== 12'd0 || ifa.tap_idx !== 4'd0 ||
            ifa.tap_pad !== 1'b1 || ifa.mac_clr !== 1'b1) begin
            bad++;
            $display("FAIL first_cycle got busy=%b iaddr=%0d tap=%0d pad=%b clr=%b want 1 0 0 1 1",
                     ifa.busy, ifa.iaddr, ifa.tap_idx, ifa.tap_pad, ifa.mac_clr);
        end
        cyc = 0; busy_cnt = 0; both = 0;
        while (ifa.busy === 1'b1 && cyc < 70000) begin
            if (ifa.crd === 1'b1 && ifa.cwr === 1'b1) both++;
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL extra_busy_cycle cyc=%0d got busy=1 want 0", cyc);
            end else begin
                e = q.pop_front();
                if (obs_a !== e) begin
                    bad++;
                    $display("FAIL seq_a cyc=%0d got=%h want=%h", cyc, obs_a, e);
                end
            end
            if (cyc == 45055) begin
                total++;
                if (ifa.cwr !== 1'b1 || ifa.caddr_wr !== 12'd4095 || ifa.csel !== 3'b010) begin
                    bad++;
                    $display("FAIL last_l0_write got cwr=%b addr=%0d csel=%b want 1 4095 010",
                             ifa.cwr, ifa.caddr_wr, ifa.csel);
                end
            end
            busy_cnt++;
            cyc++;
            ifa.ready = (cyc >= 100 && cyc < 110);
            tick();
        end
        ifa.ready = 1'b0;
        total++;
        if (busy_cnt != 59392 || q.size() != 0) begin
            bad++;
            $display("FAIL busy_count got=%0d left=%0d want 59392 left 0", busy_cnt, q.size());
        end
        total++;
        if (ifa.done !== 1'b1 || ifa.busy !== 1'b0 || obs_a !== '0) begin
            bad++;
            $display("FAIL done_pulse got done=%b busy=%b outs=%h want 1 0 0", ifa.done, ifa.busy, obs_a);
        end
        total++;
        if (both != 0) begin
            bad++;
            $display("FAIL port_exclusive got=%0d overlapping cycles want 0", both);
        end
        tick();
        total++;
        if (ifa.done !== 1'b0 || ifa.busy !== 1'b0) begin
            bad++;
            $display("FAIL done_once got done=%b busy=%b want 0 0", ifa.done, ifa.busy);
        end
    endtask

    task automatic test_mid_reset();
        int stop_at, seen_done;
        exp_t e;
        q.delete();
        push_run(3);
        stop_at = 64 * 11 + 57;
        ifb.ready = 1'b1;
        tick();
        ifb.ready = 1'b0;
        for (int cyc = 0; cyc < stop_at; cyc++) begin
            total++;
            e = q.pop_front();
            if (obs_b !== e || ifb.busy !== 1'b1) begin
                bad++;
                $display("FAIL seq_b_pre cyc=%0d got=%h busy=%b want=%h busy 1", cyc, obs_b, ifb.busy, e);
            end
            tick();
        end
        rst_b = 1'b1;
        tick();
        total++;
        if (obs_b !== '0 || ifb.busy !== 1'b0 || ifb.done !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset got=%h busy=%b done=%b want all zero", obs_b, ifb.busy, ifb.done);
        end
        rst_b = 1'b0;
        seen_done = 0;
        repeat (5) begin
            tick();
            if (ifb.done !== 1'b0 || ifb.busy !== 1'b0) seen_done++;
        end
        total++;
        if (seen_done != 0) begin
            bad++;
            $display("FAIL no_done_after_reset got=%0d active cycles want 0", seen_done);
        end
        q.delete();
    endtask

    task automatic test_restart();
        int cyc, busy_cnt;
        exp_t e;
        push_run(3);
        ifb.ready = 1'b1;
        tick();
        ifb.ready = 1'b0;
        total++;
        if (ifb.busy !== 1'b1 || ifb.iaddr !== 6'd0 || ifb.tap_pad !== 1'b1 || ifb.mac_clr !== 1'b1) begin
            bad++;
            $display("FAIL restart_first got busy=%b iaddr=%0d pad=%b clr=%b want 1 0 1 1",
                     ifb.busy, ifb.iaddr, ifb.tap_pad, ifb.mac_clr);
        end
        cyc = 0; busy_cnt = 0;
        while (ifb.busy === 1'b1 && cyc < 2000) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL extra_busy_b cyc=%0d got busy=1 want 0", cyc);
            end else begin
                e = q.pop_front();
                if (obs_b !== e) begin
                    bad++;
                    $display("FAIL seq_b cyc=%0d got=%h want=%h", cyc, obs_b, e);
                end
            end
            busy_cnt++;
            cyc++;
            tick();
        end
        total++;
        if (busy_cnt != 928 || q.size() != 0 || ifb.done !== 1'b1) begin
            bad++;
            $display("FAIL restart_end got busy=%0d left=%0d done=%b want 928 0 1", busy_cnt, q.size(), ifb.done);
        end
    endtask

    initial begin
        test_reset();
        test_full_run();
        test_mid_reset();
        test_restart();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
